// File: rtl/sevenseg_pkg.sv
// Shared types and hex-to-segment decode for the 7-segment scan controller.
// Pure definitions: no latency, no flow control.
package sevenseg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_hex7seg.sv
// Nibble to active-low 7-segment pattern; combinational, zero latency.
// No flow control.
module hex7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nib);

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// 8-digit 7-segment scanner: per-frame tear-free snapshot, blank gap per digit, mask, PWM brightness.
// an/sev_out lag the scan FSM by one cycle; no backpressure. SEVENSEG_LZB_EN adds leading-zero blanking.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int  BLANK_CYCLES = 2,
    parameter int  DWELL_CYCLES = 16,
    localparam int BRIGHT_W     = $clog2(DWELL_CYCLES)
) (
    input  logic                clk_7seg,
    input  logic                Rst,
    input  logic                src_sel,
    input  logic [31:0]         core_data,
    input  logic [31:0]         mmio_data,
    input  logic [7:0]          digit_mask,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [7:0]          an,
    output logic [6:0]          sev_out,
    output logic                frame_tick
);

    localparam int MAX_CYCLES = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_e              state, state_nxt;
    logic [2:0]          digit, digit_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                frame_start;

    logic [31:0]         snap_data;
    logic [7:0]          snap_mask;
    logic [BRIGHT_W-1:0] snap_bright;
    logic [7:0]          lz_en;
    logic [3:0]          cur_nib;
    logic [6:0]          cur_seg;
    logic                drive_on;

    always_ff @(posedge clk_7seg) begin
        if (Rst) begin
            state <= BLANK;
            digit <= 3'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            digit <= digit_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        digit_nxt = digit;
        cnt_nxt   = cnt + CNT_W'(1);
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = '0;
                end
            end
            DRIVE: begin
                if (cnt == DWELL_LAST) begin
                    state_nxt = BLANK;
                    digit_nxt = digit + 3'd1;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // First blank cycle of digit 0 is the only point where the display inputs are sampled.
    assign frame_start = (state == BLANK) && (digit == 3'd0) && (cnt == '0);

    always_ff @(posedge clk_7seg) begin
        if (Rst) begin
            snap_data   <= 32'd0;
            snap_mask   <= 8'd0;
            snap_bright <= '0;
        end else if (frame_start) begin
            snap_data   <= src_sel ? core_data : mmio_data;
            snap_mask   <= digit_mask;
            snap_bright <= brightness;
        end
    end

`ifdef SEVENSEG_LZB_EN
    // Digit i is shown when it or any more-significant nibble is nonzero; digit 0 always.
    always_comb begin
        lz_en    = 8'd0;
        lz_en[7] = (snap_data[31:28] != 4'd0);
        for (int i = 6; i >= 0; i--) begin
            lz_en[i] = lz_en[i+1] || (snap_data[4*i +: 4] != 4'd0);
        end
        lz_en[0] = 1'b1;
    end
`else
    assign lz_en = 8'hFF;
`endif

    assign cur_nib  = snap_data[{digit, 2'b00} +: 4];
    assign drive_on = (state == DRIVE) && snap_mask[digit] && lz_en[digit]
                      && (cnt <= CNT_W'(snap_bright));

    hex7seg u_hex7seg (
        .nib (cur_nib),
        .seg (cur_seg)
    );

    always_ff @(posedge clk_7seg) begin
        if (Rst) begin
            an         <= 8'hFF;
            sev_out    <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            an         <= drive_on ? ~(8'd1 << digit) : 8'hFF;
            sev_out    <= drive_on ? cur_seg : SEG_BLANK;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomized bench for sevenseg_scan_ctrl against a frame-position reference model.
module tb_sevenseg_scan_ctrl;

    localparam int SLOT  = 18;
    localparam int FRAME = 8 * SLOT;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk_7seg = 1'b0;
    logic        Rst;
    logic        src_sel;
    logic [31:0] core_data;
    logic [31:0] mmio_data;
    logic [7:0]  digit_mask;
    logic [3:0]  brightness;
    logic [7:0]  an;
    logic [6:0]  sev_out;
    logic        frame_tick;

    always #5 clk_7seg = ~clk_7seg;

    sevenseg_scan_ctrl dut (
        .clk_7seg   (clk_7seg),
        .Rst        (Rst),
        .src_sel    (src_sel),
        .core_data  (core_data),
        .mmio_data  (mmio_data),
        .digit_mask (digit_mask),
        .brightness (brightness),
        .an         (an),
        .sev_out    (sev_out),
        .frame_tick (frame_tick)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          pos   = 0;
    int          cyc   = 0;
    int          last_tick = -1;
    logic [31:0] m_data   = 32'd0;
    logic [7:0]  m_mask   = 8'd0;
    logic [3:0]  m_bright = 4'd0;
    logic [7:0]  exp_an;
    logic [6:0]  exp_sev;
    logic        exp_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic bit shown(input int slot);
`ifdef SEVENSEG_LZB_EN
        return (slot == 0) || ((m_data >> (4 * slot)) != 32'd0);
`else
        return (slot >= 0);
`endif
    endfunction

    // Expected outputs follow from where the scan sits inside the 144-cycle frame.
    task automatic step();
        int slot;
        int off;
        @(posedge clk_7seg);
        cyc++;
        exp_an   = 8'hFF;
        exp_sev  = 7'b1111111;
        exp_tick = 1'b0;
        if (Rst) begin
            pos       = 0;
            m_data    = 32'd0;
            m_mask    = 8'd0;
            m_bright  = 4'd0;
            last_tick = -1;
        end else begin
            slot     = pos / SLOT;
            off      = pos % SLOT;
            exp_tick = (pos == 0);
            if (off >= 2 && (off - 2) <= int'(m_bright) && m_mask[slot] && shown(slot)) begin
                exp_an  = ~(8'd1 << slot);
                exp_sev = HEX_TAB[4'(m_data >> (4 * slot))];
            end
            if (pos == 0) begin
                m_data   = src_sel ? core_data : mmio_data;
                m_mask   = digit_mask;
                m_bright = brightness;
            end
            pos = (pos + 1) % FRAME;
        end
        @(negedge clk_7seg);
        chk("an", 32'(an), 32'(exp_an));
        chk("sev_out", 32'(sev_out), 32'(exp_sev));
        chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
        if (frame_tick === 1'b1 && !Rst) begin
            if (last_tick >= 0) chk("tick_period", cyc - last_tick, FRAME);
            last_tick = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        Rst        = 1'b1;
        src_sel    = 1'b0;
        core_data  = 32'd0;
        mmio_data  = 32'd0;
        digit_mask = 8'hFF;
        brightness = 4'hF;
        run(3);
        Rst = 1'b0;
        run(3);
        chk("first_an", 32'(an), 32'h000000FE);
        chk("first_sev", 32'(sev_out), 32'h00000001);
        run(2 * FRAME);

        src_sel   = 1'b1;
        core_data = 32'h89ABCDEF;
        run(2 * FRAME);

        brightness = 4'd3;
        run(2 * FRAME);

        brightness = 4'hF;
        digit_mask = 8'h0F;
        run(2 * FRAME);
        digit_mask = 8'h00;
        run(FRAME);
        digit_mask = 8'hFF;

        src_sel   = 1'b0;
        mmio_data = 32'h5;
        run(FRAME + 10);
        mmio_data = 32'h7;
        run(FRAME);
        src_sel = 1'b1;
        run(FRAME);

        while ((pos % SLOT) != 6) step();
        Rst = 1'b1;
        step();
        chk("rst_abort_an", 32'(an), 32'h000000FF);
        Rst = 1'b0;
        run(FRAME);

        src_sel   = 1'b0;
        mmio_data = 32'h00000A05;
        run(2 * FRAME);
        mmio_data = 32'h0;
        run(2 * FRAME);

        for (int i = 0; i < 20 * FRAME; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 4))
                    0: src_sel    = 1'($urandom);
                    1: core_data  = $urandom >> (4 * $urandom_range(0, 7));
                    2: mmio_data  = $urandom >> (4 * $urandom_range(0, 7));
                    3: digit_mask = 8'($urandom);
                    default: brightness = 4'($urandom);
                endcase
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
